// File: rtl/mul8_arb_pkg.sv
// Shared types for the mul8_arbiter slice: FSM states, id width and the tag-pipe stage record.
package mul8_arb_pkg;

  localparam int ID_W        = 3;
  localparam int MUL_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mul8_arbiter_if.sv
// Requester, multiplier and response bus of mul8_arbiter; slave is the arbiter side.
interface mul8_arbiter_if
  import mul8_arb_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]   req_valid_i;
  logic [NREQ*8-1:0] req_a_i;
  logic [NREQ*8-1:0] req_b_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [7:0]        mul_a_o;
  logic [7:0]        mul_b_o;
  logic [7:0]        mul_p_i;
  logic              rsp_valid_o;
  logic [ID_W-1:0]   rsp_id_o;
  logic [7:0]        rsp_p_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, mul_p_i,
    output req_ready_o, mul_a_o, mul_b_o, rsp_valid_o, rsp_id_o, rsp_p_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, mul_p_i,
    input  req_ready_o, mul_a_o, mul_b_o, rsp_valid_o, rsp_id_o, rsp_p_o
  );

endinterface

// File: rtl/mul8_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter
  import mul8_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any_gnt
);

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    any_gnt = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!any_gnt && valid[k] && (k == (int'(ptr) + i) % NREQ)) begin
          any_gnt = 1'b1;
          gnt[k]  = 1'b1;
          gnt_id  = ID_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/mul8_arbiter.sv
// Round-robin scheduler sharing one fixed-latency 8-bit multiplier among NREQ requesters.
// Optional build macro MUL8_ARB_STATS_EN adds per-requester saturating grant counters.
//
//   state    | meaning
//   ST_IDLE  | nothing in flight, waiting for en_i
//   ST_RUN   | granting requests while en_i stays high
//   ST_DRAIN | no new grants, waiting for the tag pipe to empty
module mul8_arbiter
  import mul8_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  output logic               idle_o,
`ifdef MUL8_ARB_STATS_EN
  input  logic               stats_clr_i,
  output logic [NREQ*16-1:0] gnt_cnt_o,
`endif
  mul8_arbiter_if.slave      bus
);

  state_t          state, state_nxt;
  logic            issue_en, xfer, any_vld, pipe_busy;
  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_id, ptr;
  logic [7:0]      a_sel, b_sel;
  tag_t            tag [MUL_LAT+1];

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .valid   (bus.req_valid_i),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .any_gnt (any_vld)
  );

  always_comb begin
    pipe_busy = 1'b0;
    for (int s = 0; s <= MUL_LAT; s++) pipe_busy = pipe_busy | tag[s].vld;
  end

  // Grants stop in the very cycle en_i is seen low, not one cycle later.
  always_comb begin
    state_nxt = state;
    issue_en  = 1'b0;
    case (state)
      ST_IDLE:  if (en_i) state_nxt = ST_RUN;
      ST_RUN:   if (!en_i) state_nxt = ST_DRAIN;
                else issue_en = 1'b1;
      ST_DRAIN: if (!pipe_busy) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign xfer            = issue_en & any_vld;
  assign bus.req_ready_o = issue_en ? gnt : '0;
  assign idle_o          = (state == ST_IDLE);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        a_sel = bus.req_a_i[8*k +: 8];
        b_sel = bus.req_b_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      bus.mul_a_o <= '0;
      bus.mul_b_o <= '0;
    end else begin
      state       <= state_nxt;
      bus.mul_a_o <= xfer ? a_sel : '0;
      bus.mul_b_o <= xfer ? b_sel : '0;
      if (xfer) ptr <= (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  // Stage MUL_LAT lines up with mul_p_i for the same issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s <= MUL_LAT; s++) tag[s] <= '0;
    end else begin
      tag[0] <= '{vld: xfer, id: gnt_id};
      for (int s = 1; s <= MUL_LAT; s++) tag[s] <= tag[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_id_o    <= '0;
      bus.rsp_p_o     <= '0;
    end else begin
      bus.rsp_valid_o <= tag[MUL_LAT].vld;
      if (tag[MUL_LAT].vld) begin
        bus.rsp_id_o <= tag[MUL_LAT].id;
        bus.rsp_p_o  <= bus.mul_p_i;
      end
    end
  end

`ifdef MUL8_ARB_STATS_EN
  logic [NREQ-1:0][15:0] gnt_cnt;

  assign gnt_cnt_o = gnt_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr_i) begin
      gnt_cnt <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (xfer && gnt[k] && (gnt_cnt[k] != 16'hFFFF)) gnt_cnt[k] <= gnt_cnt[k] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mul8_arbiter.sv
// Scoreboard bench for mul8_arbiter with a behavioural multiplier and round-robin reference model.
module tb_mul8_arbiter;
  import mul8_arb_pkg::*;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 2;

  typedef struct {
    int id;
    int p;
    int cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic idle;
`ifdef MUL8_ARB_STATS_EN
  logic               stats_clr = 1'b0;
  logic [NREQ*16-1:0] gnt_cnt;
`endif

  mul8_arbiter_if #(.NREQ(NREQ)) bus ();

  mul8_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .idle_o      (idle),
`ifdef MUL8_ARB_STATS_EN
    .stats_clr_i (stats_clr),
    .gnt_cnt_o   (gnt_cnt),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  bit   armed = 1'b0;
  exp_t sbq[$];

  bit         pend [NREQ];
  logic [7:0] pa [NREQ];
  logic [7:0] pb [NREQ];
  int         mst;
  int         mptr;
  int         last_xfer;
  int         last_id;
  int         last_p;
  logic [7:0] exp_a, exp_b;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mulf(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = 0;
    for (int k = 1; k <= 7; k++) if (b[8-k]) s += int'(a >> k);
    return s[7:0];
  endfunction

  logic [7:0] mp [MUL_LAT];
  always @(posedge clk) begin
    mp[0] <= mulf(bus.mul_a_o, bus.mul_b_o);
    for (int s = 1; s < MUL_LAT; s++) mp[s] <= mp[s-1];
  end
  assign bus.mul_p_i = mp[MUL_LAT-1];

  task automatic chk(input string nm, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, expv);
    end
  endtask

  task automatic model_reset();
    mst       = 0;
    mptr      = 0;
    last_xfer = -100;
    exp_a     = '0;
    exp_b     = '0;
    last_id   = 0;
    last_p    = 0;
    sbq.delete();
    for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      bus.req_valid_i[k]       = pend[k];
      bus.req_a_i[8*k +: 8]    = pa[k];
      bus.req_b_i[8*k +: 8]    = pb[k];
    end
  endtask

  task automatic check_reset();
    chk("rst_rsp_valid", int'(bus.rsp_valid_o), 0);
    chk("rst_rsp_id",    int'(bus.rsp_id_o), 0);
    chk("rst_rsp_p",     int'(bus.rsp_p_o), 0);
    chk("rst_mul_a",     int'(bus.mul_a_o), 0);
    chk("rst_mul_b",     int'(bus.mul_b_o), 0);
    chk("rst_ready",     int'(bus.req_ready_o), 0);
    chk("rst_idle",      int'(idle), 1);
  endtask

  // One clock of stimulus: inputs already set, checks at negedge, model advances.
  task automatic step(input bit do_rst);
    int g;
    int ev;
    bit issue;
    drive();
    @(negedge clk);
    chk("mul_a", int'(bus.mul_a_o), int'(exp_a));
    chk("mul_b", int'(bus.mul_b_o), int'(exp_b));
    chk("idle",  int'(idle), int'(mst == 0));
    issue = (mst == 1) && en;
    g = -1;
    if (issue) begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (mptr + i) % NREQ;
        if (g < 0 && pend[k]) g = k;
      end
    end
    ev = (g >= 0) ? (1 << g) : 0;
    chk("ready", int'(bus.req_ready_o), ev);
    exp_a = '0;
    exp_b = '0;
    if (g >= 0) begin
      exp_a = pa[g];
      exp_b = pb[g];
      sbq.push_back('{id: g, p: int'(mulf(pa[g], pb[g])), cyc: cyc + MUL_LAT + 2});
      mptr      = (g + 1) % NREQ;
      last_xfer = cyc;
    end
    case (mst)
      0:       if (en) mst = 1;
      1:       if (!en) mst = 2;
      default: if (cyc - last_xfer > MUL_LAT + 1) mst = 0;
    endcase
    @(posedge clk);
    #1;
    if (do_rst) begin
      model_reset();
      rst_n = 1'b1;
    end else if (g >= 0) begin
      pend[g] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (bus.rsp_valid_o) begin
        if (sbq.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_rsp at cycle %0d: got id %0d p 0x%0h, want no response",
                   cyc, bus.rsp_id_o, bus.rsp_p_o);
        end else begin
          e = sbq.pop_front();
          chk("rsp_id",    int'(bus.rsp_id_o), e.id);
          chk("rsp_p",     int'(bus.rsp_p_o), e.p);
          chk("rsp_cycle", cyc, e.cyc);
          last_id = e.id;
          last_p  = e.p;
        end
      end else begin
        chk("rsp_id_hold", int'(bus.rsp_id_o), last_id);
        chk("rsp_p_hold",  int'(bus.rsp_p_o), last_p);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog at cycle %0d: got no finish, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    for (int k = 0; k < NREQ; k++) begin
      pa[k] = '0;
      pb[k] = '0;
    end
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    armed = 1'b1;
    check_reset();

    // single request, 0x80 * 0x80
    en = 1'b1;
    step(0);
    pend[0] = 1'b1; pa[0] = 8'h80; pb[0] = 8'h80;
    step(0);
    repeat (6) step(0);

    // all requesters valid: strict rotation from pointer 0
    rst_n = 1'b0;
    step(1);
    check_reset();
    step(0);
    repeat (8) begin
      for (int k = 0; k < NREQ; k++) begin
        pend[k] = 1'b1; pa[k] = 8'hFF; pb[k] = 8'hFF;
      end
      step(0);
    end
    for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
    repeat (6) step(0);

    // single requester streaming at full throughput
    repeat (5) begin
      pend[2] = 1'b1; pa[2] = 8'($urandom); pb[2] = 8'($urandom);
      step(0);
    end
    repeat (6) step(0);

    // random traffic with random enable toggling
    repeat (400) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!pend[k] && $urandom_range(0, 99) < 50) begin
          pend[k] = 1'b1; pa[k] = 8'($urandom); pb[k] = 8'($urandom);
        end
      end
      if ($urandom_range(0, 99) < 5) en = !en;
      step(0);
    end

    // drop enable with a full pipe, then drain to idle
    en = 1'b1;
    w = 0;
    while (mst != 1 && w < 20) begin
      step(0);
      w++;
    end
    repeat (6) begin
      for (int k = 0; k < NREQ; k++) if (!pend[k]) begin
        pend[k] = 1'b1; pa[k] = 8'($urandom); pb[k] = 8'($urandom);
      end
      step(0);
    end
    en = 1'b0;
    w = 0;
    while (!idle && w < 20) begin
      step(0);
      w++;
    end
    chk("drain_to_idle", int'(idle), 1);
    chk("drain_sb_empty", sbq.size(), 0);
    for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
    step(0);

    // reset with three issues in flight
    en = 1'b1;
    step(0);
    repeat (3) begin
      for (int k = 0; k < NREQ; k++) if (!pend[k]) begin
        pend[k] = 1'b1; pa[k] = 8'($urandom); pb[k] = 8'($urandom);
      end
      step(0);
    end
    rst_n = 1'b0;
    step(1);
    check_reset();
    repeat (6) step(0);
    for (int k = 0; k < NREQ; k++) begin
      pend[k] = 1'b1; pa[k] = 8'($urandom); pb[k] = 8'($urandom);
    end
    repeat (8) step(0);

`ifdef MUL8_ARB_STATS_EN
    rst_n = 1'b0;
    step(1);
    check_reset();
    chk("stats_rst", int'(gnt_cnt[31:16]), 0);
    step(0);
    repeat (3) begin
      pend[1] = 1'b1; pa[1] = 8'($urandom); pb[1] = 8'($urandom);
      step(0);
    end
    chk("stats_cnt3", int'(gnt_cnt[31:16]), 3);
    pend[1] = 1'b1;
    stats_clr = 1'b1;
    step(0);
    stats_clr = 1'b0;
    chk("stats_clr_wins", int'(gnt_cnt[31:16]), 0);
    repeat (65535) begin
      pend[1] = 1'b1;
      step(0);
    end
    chk("stats_full", int'(gnt_cnt[31:16]), 32'hFFFF);
    pend[1] = 1'b1;
    step(0);
    chk("stats_saturate", int'(gnt_cnt[31:16]), 32'hFFFF);
    pend[1] = 1'b0;
`endif

    for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
    repeat (8) step(0);
    chk("final_sb_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
